// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: config, run-control, sample and status signals of the pattern detector
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic [WIN_W-1:0]   cfg_window;
  logic               start;
  logic               abort;
  logic               btn_valid;
  logic               btn;
  logic               led;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               timeout;
  logic               cfg_err;
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_window,
    output start, abort, btn_valid, btn,
    input  led, match_cnt, busy, done, timeout, cfg_err
  );
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_window,
    input  start, abort, btn_valid, btn,
    output led, match_cnt, busy, done, timeout, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller counting serial pattern matches until target or window limit
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input logic clk,
  input logic rst_n,
  seq_detect_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [MAX_LEN-1:0] pattern, hist, new_hist, mask;
  logic [LEN_W-1:0]   len, fill, fill_inc;
  logic               overlap;
  logic [CNT_W-1:0]   target, cnt, cnt_nxt;
  logic [WIN_W-1:0]   window, win, win_nxt;
  logic run, samp, hit, fin, to, go, len_ok, cfg_ok, cfg_bad;
  always_comb begin
    run       = state == RUN;
    samp      = run && bus.btn_valid && !bus.abort;
    new_hist  = {hist[MAX_LEN-2:0], bus.btn};
    mask      = ~({MAX_LEN{1'b1}} << len);
    fill_inc  = fill == LEN_W'(MAX_LEN) ? fill : fill + LEN_W'(1);
    hit       = samp && ((new_hist ^ pattern) & mask) == '0 && fill_inc >= len;
    cnt_nxt   = cnt + CNT_W'(hit);
    win_nxt   = win + WIN_W'(1);
    fin       = hit && cnt_nxt == target;
    to        = samp && !fin && window != '0 && win_nxt == window;
    go        = !run && bus.start && target != '0;
    len_ok    = bus.cfg_len != '0 && bus.cfg_len <= LEN_W'(MAX_LEN);
    cfg_ok    = !run && bus.cfg_we && len_ok;
    cfg_bad   = (bus.cfg_we && !cfg_ok) || (!run && bus.start && target == '0);
    state_nxt = go ? RUN : (run && (bus.abort || fin || to)) ? IDLE : state;
  end
  // history bits survive a non-overlapping match; clearing fill alone hides them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pattern     <= '0;
      len         <= '0;
      overlap     <= 1'b0;
      target      <= '0;
      window      <= '0;
      hist        <= '0;
      fill        <= '0;
      win         <= '0;
      cnt         <= '0;
      bus.led     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.led     <= hit;
      bus.busy    <= state_nxt == RUN;
      bus.done    <= fin;
      bus.timeout <= to;
      bus.cfg_err <= cfg_bad;
      if (cfg_ok) begin
        pattern <= bus.cfg_pattern;
        len     <= bus.cfg_len;
        overlap <= bus.cfg_overlap;
        target  <= bus.cfg_target;
        window  <= bus.cfg_window;
      end
      if (go) begin
        hist <= '0;
        fill <= '0;
        win  <= '0;
        cnt  <= '0;
      end else if (samp) begin
        hist <= new_hist;
        fill <= hit && !overlap ? '0 : fill_inc;
        win  <= win_nxt;
        cnt  <= cnt_nxt;
      end
    end
  end
  assign bus.match_cnt = cnt;
endmodule
